// File: rtl/wishbone_intercon.sv
// wishbone_intercon: shared-bus Wishbone interconnect, one master to NSLAVES slaves.
// The slave index comes from the top SELW address bits. Address, write data and write
// enable are registered and shared by all slaves. Only the selected slave gets a strobe.
// That slave's ack and read data are routed back to the master.
// The master gets a bus error for an unmapped index. It also gets a bus error if the
// selected slave does not ack within TIMEOUT cycles.
// Optional feature macro: WB_INTERCON_ERRCNT_EN adds err_count[7:0]. This is a
// saturating count of bus-error pulses.
//
// Handshake: a request is accepted in IDLE when m_cyc & m_stb are both high. The
// selected slave's s_cyc/s_stb stay high until that slave's s_ack is sampled, the
// timeout expires, or the master drops m_cyc or m_stb. Each transfer ends with exactly
// one single-cycle m_ack or m_err pulse, except on a master abort, which ends with
// neither. A new transfer needs m_stb to go low first.
module wishbone_intercon #(
    parameter int NSLAVES = 3,
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int SELW    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         m_adr,
    input  logic [DW-1:0]         m_dat_w,
    input  logic                  m_we,
    input  logic                  m_stb,
    input  logic                  m_cyc,
    output logic [DW-1:0]         m_dat_r,
    output logic                  m_ack,
    output logic                  m_err,
    output logic [AW-1:0]         s_adr,
    output logic [DW-1:0]         s_dat_w,
    output logic                  s_we,
    output logic [NSLAVES-1:0]    s_cyc,
    output logic [NSLAVES-1:0]    s_stb,
    input  logic [NSLAVES*DW-1:0] s_dat_r,
    input  logic [NSLAVES-1:0]    s_ack,
    output logic [1:0]            dbg_state
`ifdef WB_INTERCON_ERRCNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SELW-1:0]     idx_q, idx_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic [DW-1:0]       dat_w_q, dat_w_d;
    logic                we_q, we_d;
    logic [NSLAVES-1:0]  stb_q, stb_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DW-1:0]       dat_r_q, dat_r_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [SELW-1:0]     req_idx;
    logic                req_mapped;
    logic [NSLAVES-1:0]  req_onehot;
    logic                sel_ack;
    logic [DW-1:0]       sel_dat;

    assign req_idx    = m_adr[AW-1 -: SELW];
    assign req_mapped = 32'(req_idx) < NSLAVES;

    // Decode the incoming index to a one-hot strobe, and mux the latched slave's ack/data.
    always_comb begin
        req_onehot = '0;
        sel_ack    = 1'b0;
        sel_dat    = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (req_idx == SELW'(i)) begin
                req_onehot[i] = 1'b1;
            end
            if (idx_q == SELW'(i)) begin
                sel_ack = s_ack[i];
                sel_dat = s_dat_r[i*DW +: DW];
            end
        end
    end

    // Next-state logic. A master abort takes priority over a same-cycle ack.
    // An ack on the last counter cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        adr_d   = adr_q;
        dat_w_d = dat_w_q;
        we_d    = we_q;
        stb_d   = stb_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_r_d = dat_r_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m_cyc && m_stb) begin
                    idx_d   = req_idx;
                    adr_d   = m_adr;
                    dat_w_d = m_dat_w;
                    we_d    = m_we;
                    cnt_d   = '0;
                    if (req_mapped) begin
                        stb_d   = req_onehot;
                        state_d = ST_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_ACCESS: begin
                if (!(m_cyc && m_stb)) begin
                    stb_d   = '0;
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    ack_d   = 1'b1;
                    stb_d   = '0;
                    state_d = ST_RELEASE;
                    if (!we_q) begin
                        dat_r_d = sel_dat;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    stb_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (!m_stb) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                stb_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            adr_q   <= '0;
            dat_w_q <= '0;
            we_q    <= 1'b0;
            stb_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            adr_q   <= adr_d;
            dat_w_q <= dat_w_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_r_q <= dat_r_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WB_INTERCON_ERRCNT_EN
    logic [7:0] err_count_q;

    // Count bus-error pulses. The count saturates at 255 and only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_count_q <= '0;
        end else if (err_d && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

    assign m_dat_r   = dat_r_q;
    assign m_ack     = ack_q;
    assign m_err     = err_q;
    assign s_adr     = adr_q;
    assign s_dat_w   = dat_w_q;
    assign s_we      = we_q;
    assign s_cyc     = stb_q;
    assign s_stb     = stb_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wishbone_intercon.sv
// Directed bench for wishbone_intercon (NSLAVES=3, AW=16, DW=8, SELW=4, TIMEOUT=15).
// A behavioural slave model acks after a programmable number of wait cycles.
// Each expected master response is queued when its request is driven.
// The response is popped and compared when m_ack or m_err appears.
module tb_wishbone_intercon;
    localparam int NS = 3;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 15;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] K_ACK      = 2'b01;
    localparam logic [1:0] K_ERR      = 2'b10;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     m_adr;
    logic [DW-1:0]     m_dat_w;
    logic              m_we, m_stb, m_cyc;
    logic [DW-1:0]     m_dat_r;
    logic              m_ack, m_err;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_w;
    logic              s_we;
    logic [NS-1:0]     s_cyc, s_stb;
    logic [NS*DW-1:0]  s_dat_r;
    logic [NS-1:0]     s_ack;
    logic [1:0]        dbg_state;
`ifdef WB_INTERCON_ERRCNT_EN
    logic [7:0]        err_count;
`endif

    logic [DW-1:0]     sd [NS];
    int                lat [NS];
    int                wcnt [NS];
    logic [NS-1:0]     ack_force;
    logic [DW+1:0]     exp_q [$];
    logic [DW-1:0]     model_dat;
    int                err_exp;
    int                n_assert;
    int                n_fail;
    logic              resp_seen;

    assign s_dat_r = {sd[2], sd[1], sd[0]};

    wishbone_intercon #(
        .NSLAVES(NS), .AW(AW), .DW(DW), .SELW(4), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_we(m_we), .m_stb(m_stb), .m_cyc(m_cyc),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .dbg_state(dbg_state)
`ifdef WB_INTERCON_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score responses, then update the slave model
    task automatic cycle();
        logic [DW+1:0] e;
        logic [NS-1:0] a;
        @(negedge clk);
        resp_seen = 1'b0;
        check("ack_err_excl", 32'(m_ack & m_err), 32'd0);
        check("stb_onehot", 32'($countones(s_stb) <= 1), 32'd1);
        check("cyc_eq_stb", 32'(s_cyc), 32'(s_stb));
        if (m_ack || m_err) begin
            resp_seen = 1'b1;
            check("resp_stb_low", 32'(s_stb), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {30'd0, m_err, m_ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_kind", {30'd0, m_err, m_ack}, 32'(e[DW+1:DW]));
                check("resp_data", 32'(m_dat_r), 32'(e[DW-1:0]));
            end
        end
        a = '0;
        for (int i = 0; i < NS; i++) begin
            if (s_stb[i] && s_cyc[i]) begin
                if (wcnt[i] >= lat[i]) a[i] = 1'b1;
                else wcnt[i]++;
            end else begin
                wcnt[i] = 0;
            end
        end
        s_ack = a | ack_force;
    endtask

    task automatic check_reset_state();
        check("rst_m_ack", 32'(m_ack), 32'd0);
        check("rst_m_err", 32'(m_err), 32'd0);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        check("rst_s_we", 32'(s_we), 32'd0);
        check("rst_m_dat_r", 32'(m_dat_r), 32'd0);
        check("rst_s_adr", 32'(s_adr), 32'd0);
        check("rst_s_dat_w", 32'(s_dat_w), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Complete transfer: queue the expected response, request, wait, release
    task automatic xfer(input logic [AW-1:0] adr, input logic [DW-1:0] wd, input logic we,
                        input logic [1:0] kind, input logic [DW-1:0] rdat,
                        input int exp_lat, input logic [NS-1:0] exp_stb);
        int k;
        if (kind == K_ACK && !we) model_dat = rdat;
        if (kind == K_ERR) err_exp = (err_exp < 255) ? err_exp + 1 : 255;
        exp_q.push_back({kind, model_dat});
        m_adr = adr; m_dat_w = wd; m_we = we; m_cyc = 1'b1; m_stb = 1'b1;
        k = 0;
        do begin
            cycle();
            k++;
            if (k == 1) begin
                check("strobe_sel", 32'(s_stb), 32'(exp_stb));
                check("s_adr", 32'(s_adr), 32'(adr));
                check("s_we", 32'(s_we), 32'(we));
                check("s_dat_w", 32'(s_dat_w), 32'(wd));
            end
        end while (!resp_seen && k < 64);
        check("resp_within_budget", 32'(resp_seen), 32'd1);
        check("latency", 32'(k), 32'(exp_lat));
        cycle();
        check("release_hold_state", 32'(dbg_state), 32'(ST_RELEASE));
        check("release_no_restrobe", 32'(s_stb), 32'd0);
        m_cyc = 1'b0; m_stb = 1'b0;
        cycle();
        check("back_to_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_assert = 0; n_fail = 0; err_exp = 0; model_dat = '0;
        reset = 1'b0; m_adr = '0; m_dat_w = '0; m_we = 1'b0; m_stb = 1'b0; m_cyc = 1'b0;
        s_ack = '0; ack_force = '0;
        for (int i = 0; i < NS; i++) begin sd[i] = '0; lat[i] = 0; wcnt[i] = 0; end

        // Reset state
        repeat (3) cycle();
        check_reset_state();
        reset = 1'b1;
        cycle();

        // Read slave 1, zero-wait slave: m_ack two cycles after the request
        sd[1] = 8'hA5; lat[1] = 0;
        xfer(16'h1005, 8'h00, 1'b0, K_ACK, 8'hA5, 2, 3'b010);

        // Write slave 2 with three wait states; m_dat_r holds the last read data
        sd[2] = 8'h11; lat[2] = 3;
        xfer(16'h2010, 8'h3C, 1'b1, K_ACK, 8'h00, 5, 3'b100);

        // Unmapped index: error one cycle after the request, no strobe
        xfer(16'hF000, 8'h00, 1'b0, K_ERR, 8'h00, 1, 3'b000);
        xfer(16'h3000, 8'h00, 1'b0, K_ERR, 8'h00, 1, 3'b000);

        // Slave 0 never acks: error after TIMEOUT access cycles
        lat[0] = 1000;
        xfer(16'h0042, 8'h00, 1'b0, K_ERR, 8'h00, TO + 1, 3'b001);

        // Ack on the last counter cycle wins over the timeout
        sd[0] = 8'h96; lat[0] = TO - 1;
        xfer(16'h0043, 8'h00, 1'b0, K_ACK, 8'h96, TO + 1, 3'b001);

        // Master abort in the second access cycle; a late ack must be ignored
        lat[0] = 4;
        m_adr = 16'h0ABC; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        cycle();
        check("abort_strobed", 32'(s_stb), 32'b001);
        cycle();
        check("abort_access", 32'(dbg_state), 32'(ST_ACCESS));
        m_stb = 1'b0;
        cycle();
        check("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_stb_low", 32'(s_stb), 32'd0);
        ack_force = 3'b001;
        cycle();
        cycle();
        ack_force = '0;
        m_cyc = 1'b0;
        cycle();
        check("abort_still_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Back-to-back reads to slaves 0 and 2; a stray ack from slave 2 during slave 0's access
        sd[0] = 8'h5A; lat[0] = 1;
        sd[2] = 8'hC3; lat[2] = 0;
        ack_force = 3'b100;
        xfer(16'h0007, 8'h00, 1'b0, K_ACK, 8'h5A, 3, 3'b001);
        ack_force = '0;
        xfer(16'h2FFF, 8'h00, 1'b0, K_ACK, 8'hC3, 2, 3'b100);

`ifdef WB_INTERCON_ERRCNT_EN
        check("err_count_mid", 32'(err_count), 32'(err_exp));
`endif

        // Reset during ACCESS clears everything without a response
        lat[1] = 1000;
        m_adr = 16'h1005; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        cycle();
        cycle();
        check("pre_reset_access", 32'(dbg_state), 32'(ST_ACCESS));
        reset = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        cycle();
        check_reset_state();
        model_dat = '0; err_exp = 0;
`ifdef WB_INTERCON_ERRCNT_EN
        check("err_count_reset", 32'(err_count), 32'd0);
`endif
        reset = 1'b1;
        cycle();

        // Normal transfer after the reset
        sd[1] = 8'h77; lat[1] = 2;
        xfer(16'h1FF0, 8'h00, 1'b0, K_ACK, 8'h77, 4, 3'b010);

`ifdef WB_INTERCON_ERRCNT_EN
        xfer(16'hE000, 8'h00, 1'b0, K_ERR, 8'h00, 1, 3'b000);
        check("err_count_one", 32'(err_count), 32'd1);
        for (int i = 0; i < 299; i++) begin
            xfer(16'h8000 + 16'(i), 8'h00, 1'b0, K_ERR, 8'h00, 1, 3'b000);
        end
        check("err_count_sat", 32'(err_count), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
